// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data-memory controller:
// access-size encodings, controller state encoding, size normalisation.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Encoding 2'b11 is handled as a word access.
    function automatic size_e norm_size(input logic [1:0] sz);
        case (sz)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM-stage controller (master)
// and the memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the byte/half addressed by the low address
// bits and sign- or zero-extends it; words pass through unchanged.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension.
    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: turns EX/MEM load/store control into
// a req/ack bus transaction, stalls the pipeline until ack or timeout, and
// aligns/extends load data for MEM/WB.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the
// bus and pulse MisAlign_MEM; without it the low address bits are ignored.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MemRead_MEM,
    input  logic                      MemWrite_MEM,
    input  logic [1:0]                MemSize_MEM,
    input  logic                      MemSigned_MEM,
    input  logic [31:0]               ALUOut_MEM,
    input  logic [31:0]               WriteData_MEM,
    mem_access_unit_if.master         bus,
    output logic [31:0]               ReadData_MEM,
    output logic                      Stall_MEM,
    output logic                      BusErr_MEM,
    output logic                      MisAlign_MEM
);

    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_e      state_q;
    logic        bus_req_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic        signed_q;
    logic [31:0] rdata_q;
    logic        buserr_q;
    logic        misalign_q;
    logic [CW-1:0] cnt_q;

    logic        access;
    size_e       size_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        trap_d;
    logic [31:0] load_data;

    // Byte enables, store-data replication and misalignment decode.
    always_comb begin
        access = MemRead_MEM | MemWrite_MEM;
        size_d = norm_size(MemSize_MEM);
        case (size_d)
            SZ_BYTE: begin
                be_d    = 4'b0001 << ALUOut_MEM[1:0];
                wdata_d = {4{WriteData_MEM[7:0]}};
            end
            SZ_HALF: begin
                be_d    = ALUOut_MEM[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteData_MEM[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WriteData_MEM;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        trap_d = access & (((size_d == SZ_HALF) & ALUOut_MEM[0]) |
                           ((size_d == SZ_WORD) & (ALUOut_MEM[1:0] != 2'b00)));
`else
        trap_d = 1'b0;
`endif
    end

    mem_load_align u_align (
        .word_i    (bus.bus_rdata),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .data_o    (load_data)
    );

    // Controller FSM with registered bus outputs, load result and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            addr_lo_q  <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            rdata_q    <= '0;
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_d) begin
                        state_q    <= DONE;
                        misalign_q <= 1'b1;
                        rdata_q    <= '0;
                    end else if (access) begin
                        state_q   <= BUSY;
                        bus_req_q <= 1'b1;
                        we_q      <= MemWrite_MEM;
                        addr_q    <= ALUOut_MEM[31:2];
                        addr_lo_q <= ALUOut_MEM[1:0];
                        be_q      <= be_d;
                        wdata_q   <= wdata_d;
                        size_q    <= size_d;
                        signed_q  <= MemSigned_MEM;
                        cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        if (!we_q) rdata_q <= load_data;
                    end else if ((BUS_TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        rdata_q   <= '0;
                        buserr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q, 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    assign ReadData_MEM = rdata_q;
    assign Stall_MEM    = ((state_q == IDLE) & access) | (state_q == BUSY);
    assign BusErr_MEM   = buserr_q;
    assign MisAlign_MEM = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default BUS_TIMEOUT=16).
// Honours MISALIGN_TRAP_EN for the misaligned-access step.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead_MEM = 1'b0;
    logic        MemWrite_MEM = 1'b0;
    logic [1:0]  MemSize_MEM = 2'b00;
    logic        MemSigned_MEM = 1'b0;
    logic [31:0] ALUOut_MEM = '0;
    logic [31:0] WriteData_MEM = '0;
    logic [31:0] ReadData_MEM;
    logic        Stall_MEM;
    logic        BusErr_MEM;
    logic        MisAlign_MEM;

    int checks = 0;
    int errors = 0;

    // Results captured by do_access
    int          n_stall, n_req, n_iter;
    logic [31:0] cap_addr, cap_wdata, done_rdata;
    logic [3:0]  cap_be;
    logic        cap_we, done_err, done_mis, done_req;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.BUS_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .MemSize_MEM   (MemSize_MEM),
        .MemSigned_MEM (MemSigned_MEM),
        .ALUOut_MEM    (ALUOut_MEM),
        .WriteData_MEM (WriteData_MEM),
        .bus           (bus_if),
        .ReadData_MEM  (ReadData_MEM),
        .Stall_MEM     (Stall_MEM),
        .BusErr_MEM    (BusErr_MEM),
        .MisAlign_MEM  (MisAlign_MEM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one access from IDLE through DONE and back to IDLE.
    // ack_at = BUSY cycle (1-based) in which bus_ack is pulsed; 0 = never.
    task automatic do_access(input logic r, input logic w, input logic [1:0] sz,
                             input logic s, input logic [31:0] a, input logic [31:0] d,
                             input int ack_at, input logic [31:0] rword);
        int busy_k;
        MemRead_MEM = r; MemWrite_MEM = w; MemSize_MEM = sz; MemSigned_MEM = s;
        ALUOut_MEM = a; WriteData_MEM = d;
        #1;
        n_stall = 0; n_req = 0; n_iter = 0; busy_k = 0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        while (Stall_MEM === 1'b1 && n_iter < 100) begin
            n_stall++;
            if (bus_if.bus_req === 1'b1) begin
                busy_k++;
                n_req++;
                if (busy_k == 1) begin
                    cap_addr = bus_if.bus_addr; cap_be = bus_if.bus_be;
                    cap_wdata = bus_if.bus_wdata; cap_we = bus_if.bus_we;
                end
            end
            if (busy_k != 0 && busy_k == ack_at) begin
                bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rword;
            end else begin
                bus_if.bus_ack = 1'b0;
            end
            tick();
            bus_if.bus_ack = 1'b0;
            n_iter++;
        end
        done_rdata = ReadData_MEM; done_err = BusErr_MEM;
        done_mis = MisAlign_MEM; done_req = bus_if.bus_req;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        tick();
    endtask

    initial begin
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_req", bus_if.bus_req, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_be", bus_if.bus_be, 0);
        chk("rst_rdata", ReadData_MEM, 0);
        chk("rst_stall", Stall_MEM, 0);
        rst_n = 1'b1;
        tick();

        // lw 0x100, ack in 3rd BUSY cycle
        do_access(1, 0, 2'b10, 0, 32'h100, 0, 3, 32'hDEADBEEF);
        chk("lw_bound", n_iter, 4);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", cap_be, 4'b1111);
        chk("lw_we", cap_we, 0);
        chk("lw_stall", n_stall, 4);
        chk("lw_reqcyc", n_req, 3);
        chk("lw_rdata", done_rdata, 32'hDEADBEEF);
        chk("lw_done_req", done_req, 0);

        // lb signed / lbu at 0x103
        do_access(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h80FF1234);
        chk("lb_stall", n_stall, 2);
        chk("lb_be", cap_be, 4'b1000);
        chk("lb_rdata", done_rdata, 32'hFFFFFF80);
        do_access(1, 0, 2'b00, 0, 32'h103, 0, 1, 32'h80FF1234);
        chk("lbu_rdata", done_rdata, 32'h00000080);

        // sh at 0x102: read data must hold the previous load result
        do_access(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 2, 32'h55555555);
        chk("sh_we", cap_we, 1);
        chk("sh_addr", cap_addr, 32'h100);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_rdata", done_rdata, 32'h00000080);

        // Read and write both set -> write; sb at 0x001
        do_access(1, 1, 2'b00, 0, 32'h001, 32'hFFFFFF5A, 1, 32'h11111111);
        chk("sb_we", cap_we, 1);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wdata, 32'h5A5A5A5A);
        chk("sb_rdata", done_rdata, 32'h00000080);

        // sw with size 11 treated as word
        do_access(0, 1, 2'b11, 0, 32'h208, 32'h01020304, 1, 0);
        chk("sw11_be", cap_be, 4'b1111);
        chk("sw11_wdata", cap_wdata, 32'h01020304);

        // Halfword loads
        do_access(1, 0, 2'b01, 0, 32'h100, 0, 1, 32'h80FF1234);
        chk("lhu_be", cap_be, 4'b0011);
        chk("lhu_rdata", done_rdata, 32'h00001234);
        do_access(1, 0, 2'b01, 1, 32'h102, 0, 1, 32'h80FF1234);
        chk("lh_rdata", done_rdata, 32'hFFFF80FF);

        // Timeout: no ack
        do_access(1, 0, 2'b10, 0, 32'h300, 0, 0, 0);
        chk("tmo_reqcyc", n_req, 16);
        chk("tmo_stall", n_stall, 17);
        chk("tmo_err", done_err, 1);
        chk("tmo_rdata", done_rdata, 0);
        chk("tmo_err_pulse", BusErr_MEM, 0);
        chk("tmo_resume", Stall_MEM, 0);

        // Back-to-back access after the timeout
        do_access(1, 0, 2'b10, 0, 32'h104, 0, 1, 32'hCAFEF00D);
        chk("b2b_addr", cap_addr, 32'h104);
        chk("b2b_rdata", done_rdata, 32'hCAFEF00D);
        chk("b2b_err", done_err, 0);

        // Misaligned word load at 0x101
        do_access(1, 0, 2'b10, 0, 32'h101, 0, 1, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
        chk("mis_reqcyc", n_req, 0);
        chk("mis_stall", n_stall, 1);
        chk("mis_pulse", done_mis, 1);
        chk("mis_rdata", done_rdata, 0);
`else
        chk("mis_reqcyc", n_req, 1);
        chk("mis_addr", cap_addr, 32'h100);
        chk("mis_be", cap_be, 4'b1111);
        chk("mis_pulse", done_mis, 0);
        chk("mis_rdata", done_rdata, 32'h11223344);
`endif
        chk("mis_after", MisAlign_MEM, 0);

        // Reset in BUSY, then a stray ack
        MemRead_MEM = 1'b1; MemSize_MEM = 2'b10; ALUOut_MEM = 32'h400;
        tick();
        chk("rstm_req_busy", bus_if.bus_req, 1);
        MemRead_MEM = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_req_async", bus_if.bus_req, 0);
        chk("rstm_rdata_async", ReadData_MEM, 0);
        tick();
        rst_n = 1'b1;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
        tick();
        bus_if.bus_ack = 1'b0;
        tick();
        chk("rstm_rdata", ReadData_MEM, 0);
        chk("rstm_stall", Stall_MEM, 0);
        chk("rstm_req", bus_if.bus_req, 0);
        chk("rstm_addr", bus_if.bus_addr, 0);
        chk("rstm_be", bus_if.bus_be, 0);
        chk("rstm_wdata", bus_if.bus_wdata, 0);
        chk("rstm_we", bus_if.bus_we, 0);
        chk("rstm_err", BusErr_MEM, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
